// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - AHB-Lite encodings, burst master FSM states and address helper
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DRAIN,
    ST_ERR1,
    ST_REJ
  } state_e;

  // Callers zero-extend to 64 bits and truncate the result back to their address width.
  function automatic logic [63:0] addr_incr(input logic [63:0] addr, input logic [2:0] size);
    return addr + (64'd1 << size);
  endfunction

endpackage

// File: rtl/ahbl_burst_chk.sv
// rtl/ahbl_burst_chk.sv - masked read-data compare with sticky fail flag and saturating fail count
module ahbl_burst_chk #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [DATA_WIDTH-1:0] mask_i,
  output logic                  failed_o,
  output logic [15:0]           fail_count_o
);

  logic        failed_q, failed_d;
  logic [15:0] count_q, count_d;
  logic        mismatch;

  always_comb begin
    mismatch = ((data_i ^ exp_i) & mask_i) != '0;
    failed_d = failed_q;
    count_d  = count_q;
    if (en_i && mismatch) begin
      failed_d = 1'b1;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      failed_q <= 1'b0;
      count_q  <= '0;
    end else begin
      failed_q <= failed_d;
      count_q  <= count_d;
    end
  end

  assign failed_o     = failed_q;
  assign fail_count_o = count_q;

endmodule

// File: rtl/ahbl_burst_master.sv
// rtl/ahbl_burst_master.sv - command-driven AHB-Lite burst master with per-beat responses and read checking
module ahbl_burst_master
  import ahbl_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int MAX_BURST  = 16,
  localparam int LW         = $clog2(MAX_BURST) + 1
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic                  CMD_CHECK,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [2:0]            CMD_SIZE,
  input  logic [LW-1:0]         CMD_LEN,
  input  logic [DATA_WIDTH-1:0] CMD_EXP,
  input  logic [DATA_WIDTH-1:0] CMD_MASK,
  input  logic                  WD_VALID,
  output logic                  WD_READY,
  input  logic [DATA_WIDTH-1:0] WD_DATA,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_ERR,
  output logic                  RSP_LAST,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  BUSY,
  output logic                  FAILED,
  output logic [15:0]           FAIL_COUNT
);

  localparam int SIZE_MAX = $clog2(DATA_WIDTH / 8);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]         left_q, left_d;
  logic                  write_q, write_d, check_q, check_d;
  logic [2:0]            size_q, size_d, burst_q, burst_d;
  logic                  first_q, first_d, dph_q, dph_d, dph_last_q, dph_last_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d, exp_q, exp_d, mask_q, mask_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_last_q, rsp_last_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] amask;
  logic                  present, dph_done, dph_err, reject, chk_en;

  always_comb begin
    state_d = state_q;      addr_d = addr_q;       left_d = left_q;
    write_d = write_q;      check_d = check_q;     size_d = size_q;
    burst_d = burst_q;      first_d = first_q;     dph_d = dph_q;
    dph_last_d = dph_last_q; hwdata_d = hwdata_q;  exp_d = exp_q;
    mask_d = mask_q;
    rsp_valid_d = 1'b0;     rsp_err_d = 1'b0;      rsp_last_d = 1'b0;
    rsp_data_d = '0;
    CMD_READY = 1'b0;       WD_READY = 1'b0;       HTRANS = HTRANS_IDLE;
    chk_en = 1'b0;
    amask    = (ADDR_WIDTH'(1) << CMD_SIZE) - ADDR_WIDTH'(1);
    reject   = (CMD_SIZE > 3'(SIZE_MAX)) || ((CMD_ADDR & amask) != '0) ||
               (CMD_LEN == '0) || (CMD_LEN > LW'(MAX_BURST));
    present  = !write_q || WD_VALID;
    dph_done = dph_q && HREADY && !HRESP;
    dph_err  = dph_q && HRESP && !HREADY;

    case (state_q)
      ST_IDLE: begin
        // The RSP_LAST cycle of the previous command still belongs to it.
        CMD_READY = !rsp_valid_q;
        if (CMD_VALID && CMD_READY) begin
          addr_d  = CMD_ADDR;    left_d  = CMD_LEN;    write_d = CMD_WRITE;
          check_d = CMD_CHECK;   size_d  = CMD_SIZE;   first_d = 1'b1;
          exp_d   = CMD_EXP;     mask_d  = CMD_MASK;
          burst_d = (CMD_LEN == LW'(1)) ? HBURST_SINGLE : HBURST_INCR;
          if (reject) begin
            state_d     = ST_REJ;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_last_d  = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR, ST_DRAIN: begin
        if (dph_done) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = dph_last_q;
          rsp_data_d  = write_q ? '0 : HRDATA;
          chk_en      = !write_q && check_q;
        end
        if (HREADY) dph_d = 1'b0;
        if (state_q == ST_ADDR) begin
          if (present) HTRANS = (first_q || addr_q[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
          else         HTRANS = first_q ? HTRANS_IDLE : HTRANS_BUSY;
          if (HREADY && present) begin
            WD_READY   = write_q;
            if (write_q) hwdata_d = WD_DATA;
            addr_d     = ADDR_WIDTH'(addr_incr(64'(addr_q), size_q));
            left_d     = left_q - LW'(1);
            first_d    = 1'b0;
            dph_d      = 1'b1;
            dph_last_d = (left_q == LW'(1));
            if (left_q == LW'(1)) state_d = ST_DRAIN;
          end
        end else if (dph_done) begin
          state_d = ST_IDLE;
        end
        // First error cycle: drop the pending address phase and finish the command.
        if (dph_err) begin
          state_d     = ST_ERR1;
          dph_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
        end
      end
      ST_ERR1: state_d = ST_IDLE;
      ST_REJ:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state_q <= ST_IDLE;   addr_q <= '0;        left_q <= '0;
      write_q <= 1'b0;      check_q <= 1'b0;     size_q <= HSIZE_WORD;
      burst_q <= HBURST_SINGLE; first_q <= 1'b0; dph_q <= 1'b0;
      dph_last_q <= 1'b0;   hwdata_q <= '0;      exp_q <= '0;
      mask_q <= '0;         rsp_valid_q <= 1'b0; rsp_err_q <= 1'b0;
      rsp_last_q <= 1'b0;   rsp_data_q <= '0;
    end else begin
      state_q <= state_d;   addr_q <= addr_d;    left_q <= left_d;
      write_q <= write_d;   check_q <= check_d;  size_q <= size_d;
      burst_q <= burst_d;   first_q <= first_d;  dph_q <= dph_d;
      dph_last_q <= dph_last_d; hwdata_q <= hwdata_d; exp_q <= exp_d;
      mask_q <= mask_d;     rsp_valid_q <= rsp_valid_d; rsp_err_q <= rsp_err_d;
      rsp_last_q <= rsp_last_d; rsp_data_q <= rsp_data_d;
    end
  end

  ahbl_burst_chk #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
    .clk_i        (SYSCLK),
    .rst_i        (SYSRST),
    .en_i         (chk_en),
    .data_i       (HRDATA),
    .exp_i        (exp_q),
    .mask_i       (mask_q),
    .failed_o     (FAILED),
    .fail_count_o (FAIL_COUNT)
  );

  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = size_q;
  assign HBURST    = burst_q;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_LAST  = rsp_last_q;
  assign BUSY      = (state_q != ST_IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_ahbl_burst_master.sv
// tb/tb_ahbl_burst_master.sv - directed self-checking bench for ahbl_burst_master
module tb_ahbl_burst_master;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_check = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_exp = '0, cmd_mask = '0;
  logic [2:0]  cmd_size = 3'd2;
  logic [4:0]  cmd_len = 5'd1;
  logic        wd_valid = 1'b0, wd_ready;
  logic [31:0] wd_data = '0, rsp_data, haddr, hwdata, hrdata = '0;
  logic        rsp_valid, rsp_err, rsp_last, hwrite, hmastlock, busy, failed;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hready = 1'b1, hresp = 1'b0;
  logic [15:0] fail_count;

  int checks = 0, errors = 0;

  logic [31:0] rd_addr [4] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
  logic [1:0]  rd_tr   [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
  logic        wr_v    [7] = '{1, 0, 0, 1, 1, 0, 0};
  logic [1:0]  wr_tr   [7] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [31:0] wr_addr [5] = '{32'h2000, 32'h2004, 32'h2004, 32'h2004, 32'h2008};
  logic        wr_rdy  [7] = '{1, 0, 0, 1, 1, 0, 0};
  logic        wr_rv   [7] = '{0, 0, 1, 0, 0, 1, 1};
  logic [31:0] wr_hw   [7] = '{32'h0, 32'hD0000000, 32'hD0000000, 32'hD0000000,
                               32'hD0000003, 32'hD0000004, 32'hD0000004};
  logic        er_rdy  [8] = '{1, 1, 0, 0, 1, 0, 1, 1};
  logic        er_resp [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
  logic [1:0]  er_tr   [8] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [31:0] er_addr [6] = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h300C};
  logic        er_rv   [8] = '{0, 0, 1, 0, 0, 1, 1, 0};
  logic [31:0] rj_addr [4] = '{32'h2, 32'h10, 32'h20, 32'h30};
  logic [2:0]  rj_size [4] = '{3'd2, 3'd3, 3'd2, 3'd2};
  logic [4:0]  rj_len  [4] = '{5'd1, 5'd1, 5'd0, 5'd17};

  ahbl_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(16)) dut (
    .SYSCLK(clk), .SYSRST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write), .CMD_CHECK(cmd_check),
    .CMD_ADDR(cmd_addr), .CMD_SIZE(cmd_size), .CMD_LEN(cmd_len), .CMD_EXP(cmd_exp), .CMD_MASK(cmd_mask),
    .WD_VALID(wd_valid), .WD_READY(wd_ready), .WD_DATA(wd_data),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err), .RSP_LAST(rsp_last),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HRDATA(hrdata),
    .HREADY(hready), .HRESP(hresp), .BUSY(busy), .FAILED(failed), .FAIL_COUNT(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [4:0] l);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_len = l;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_htrans", htrans, 0);
    chk("rst_hsize", hsize, 3'b010);
    chk("rst_hprot", hprot, 4'b0011);
    chk("rst_haddr", haddr, 0);
    chk("rst_hburst", hburst, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_failed", failed, 0);
    rst = 1'b0;
    step();

    // single write
    wd_valid = 1'b1; wd_data = 32'hA5A5_0001;
    #2 chk("sw_ready_before", cmd_ready, 1);
    send(1'b1, 32'h1000, 3'd2, 5'd1);
    #2;
    chk("sw_htrans", htrans, 2);
    chk("sw_hburst", hburst, 0);
    chk("sw_haddr", haddr, 32'h1000);
    chk("sw_hwrite", hwrite, 1);
    chk("sw_wd_ready", wd_ready, 1);
    chk("sw_busy", busy, 1);
    step(); wd_valid = 1'b0;
    #2;
    chk("sw_hwdata", hwdata, 32'hA5A5_0001);
    chk("sw_htrans_idle", htrans, 0);
    chk("sw_no_rsp_yet", rsp_valid, 0);
    step(); #2;
    chk("sw_rsp_valid", rsp_valid, 1);
    chk("sw_rsp_last", rsp_last, 1);
    chk("sw_rsp_err", rsp_err, 0);
    chk("sw_ready_in_last", cmd_ready, 0);
    step(); #2;
    chk("sw_busy_done", busy, 0);
    chk("sw_ready_after", cmd_ready, 1);

    // read burst across a 1 KB boundary
    send(1'b0, 32'h3F8, 3'd2, 5'd4);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      hrdata = 32'hC0DE_0000 + k;
      #2;
      if (k < 4) begin
        chk($sformatf("rb_haddr%0d", k), haddr, rd_addr[k]);
        chk($sformatf("rb_htrans%0d", k), htrans, rd_tr[k]);
      end else begin
        chk($sformatf("rb_htrans%0d", k), htrans, 0);
      end
      if (k == 0) chk("rb_hburst", hburst, 1);
      chk($sformatf("rb_rsp_valid%0d", k), rsp_valid, k >= 2);
      if (k >= 2) chk($sformatf("rb_rsp_data%0d", k), rsp_data, 32'hC0DE_0000 + 32'(k - 1));
      chk($sformatf("rb_rsp_last%0d", k), rsp_last, k == 5);
    end
    step(); #2;
    chk("rb_busy_done", busy, 0);

    // write burst with write data stalled before the second beat
    wd_valid = 1'b1; wd_data = 32'hD000_0000;
    send(1'b1, 32'h2000, 3'd2, 5'd3);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      wd_valid = wr_v[k];
      wd_data  = 32'hD000_0000 + k;
      #2;
      chk($sformatf("wb_htrans%0d", k), htrans, wr_tr[k]);
      if (k < 5) chk($sformatf("wb_haddr%0d", k), haddr, wr_addr[k]);
      chk($sformatf("wb_wd_ready%0d", k), wd_ready, wr_rdy[k]);
      chk($sformatf("wb_rsp_valid%0d", k), rsp_valid, wr_rv[k]);
      chk($sformatf("wb_rsp_last%0d", k), rsp_last, k == 6);
      if (k > 0) chk($sformatf("wb_hwdata%0d", k), hwdata, wr_hw[k]);
    end
    wd_valid = 1'b0;
    step();

    // read burst with wait states then an error response
    send(1'b0, 32'h3000, 3'd2, 5'd4);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      hready = er_rdy[k]; hresp = er_resp[k]; hrdata = 32'hE000_0000 + k;
      #2;
      chk($sformatf("er_htrans%0d", k), htrans, er_tr[k]);
      if (k < 6) chk($sformatf("er_haddr%0d", k), haddr, er_addr[k]);
      chk($sformatf("er_rsp_valid%0d", k), rsp_valid, er_rv[k]);
      chk($sformatf("er_rsp_err%0d", k), rsp_err, k == 6);
      chk($sformatf("er_rsp_last%0d", k), rsp_last, k == 6);
      chk($sformatf("er_busy%0d", k), busy, k < 7);
      if (k == 2) chk("er_rsp_data2", rsp_data, 32'hE000_0001);
      if (k == 5) chk("er_rsp_data5", rsp_data, 32'hE000_0004);
    end
    chk("er_ready_after", cmd_ready, 1);
    hready = 1'b1; hresp = 1'b0;

    // masked read checking
    cmd_check = 1'b1; cmd_exp = 32'h1234_5678; cmd_mask = 32'hFFFF_0000;
    send(1'b0, 32'h4000, 3'd2, 5'd1);
    step(); hrdata = 32'h1234_0000;
    step(); #2;
    chk("ck1_rsp_data", rsp_data, 32'h1234_0000);
    chk("ck1_failed", failed, 0);
    chk("ck1_count", fail_count, 0);
    step();
    send(1'b0, 32'h4004, 3'd2, 5'd1);
    step(); hrdata = 32'h1235_5678;
    step(); #2;
    chk("ck2_rsp_err", rsp_err, 0);
    chk("ck2_failed", failed, 1);
    chk("ck2_count", fail_count, 1);
    step();
    send(1'b0, 32'h4008, 3'd2, 5'd1);
    step(); hrdata = 32'h0000_FFFF;
    step(); #2;
    chk("ck3_failed", failed, 1);
    chk("ck3_count", fail_count, 2);
    step();
    cmd_check = 1'b0;

    // rejected commands
    for (int k = 0; k < 4; k++) begin
      send(1'b0, rj_addr[k], rj_size[k], rj_len[k]);
      #2;
      chk($sformatf("rj_htrans%0d", k), htrans, 0);
      chk($sformatf("rj_rsp_valid%0d", k), rsp_valid, 1);
      chk($sformatf("rj_rsp_err%0d", k), rsp_err, 1);
      chk($sformatf("rj_rsp_last%0d", k), rsp_last, 1);
      chk($sformatf("rj_ready%0d", k), cmd_ready, 0);
      step(); #2;
      chk($sformatf("rj_rsp_clear%0d", k), rsp_valid, 0);
      chk($sformatf("rj_ready_after%0d", k), cmd_ready, 1);
    end

    // reset in the middle of a burst
    send(1'b0, 32'h5000, 3'd2, 5'd4);
    step(); #2;
    chk("mr_htrans_seq", htrans, 3);
    rst = 1'b1;
    #1;
    chk("mr_htrans", htrans, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_failed", failed, 0);
    chk("mr_count", fail_count, 0);
    chk("mr_busy", busy, 0);
    step(); rst = 1'b0;
    #2;
    chk("mr_no_rsp0", rsp_valid, 0);
    step(); #2;
    chk("mr_no_rsp1", rsp_valid, 0);
    chk("mr_htrans_idle", htrans, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
